// File: rtl/ccff_loader.sv
// ccff_loader: serial loader for the logic-tile configuration flip-flop chain.
// Host words arrive on a valid/ready stream and are shifted MSB-first onto
// ccff_head with one ccff_clk_en pulse per bit. Each pass moves exactly
// CHAIN_LEN bits. An optional second pass re-streams the same bits and
// compares ccff_tail against ccff_head to read the chain back.
module ccff_loader #(
  parameter int CHAIN_LEN = 160,
  parameter int WORD_W    = 8,
  parameter int ERRCNT_W  = 8
) (
  input  logic                prog_clk,
  input  logic                pReset_n,
  input  logic                start,
  input  logic                verify,
  input  logic                abort,
  input  logic [WORD_W-1:0]   cfg_data,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  output logic                ccff_head,
  output logic                ccff_clk_en,
  input  logic                ccff_tail,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WBL_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [WBL_W-1:0] WORD_C = WBL_W'(WORD_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Saturating increment for the mismatch counter.
  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Bits taken from a word: a full word, or only what is left of the pass.
  function automatic logic [WBL_W-1:0] word_bits(input logic [CNT_W-1:0] rem);
    if (32'(rem) >= 32'(WORD_W)) return WORD_C;
    return WBL_W'(rem);
  endfunction

  state_t                state, state_nx;
  logic                  vfy_lat, vfy_lat_nx;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nx;   // bits issued in this pass
  logic [WBL_W-1:0]      wbl, wbl_nx;           // bits of the word still to shift
  logic [WORD_W-1:0]     shreg, shreg_nx;
  logic                  head_nx, clk_en_nx, ready_nx, busy_nx, done_nx;
  logic                  error_nx;
  logic [ERRCNT_W-1:0]   err_cnt_nx;

  // bit_cnt reaching CHAIN_LEN means the current cycle carries the last bit
  // of the pass; the next word (verify pass) then counts from zero again.
  logic                  pass_end;
  logic [CNT_W-1:0]      cnt_base;
  logic                  take;

  assign pass_end = (bit_cnt == LEN_C);
  assign cnt_base = pass_end ? '0 : bit_cnt;
  assign take     = cfg_valid && cfg_ready;

  // Next-state, shift scheduling and registered-output values.
  always_comb begin
    state_nx   = state;
    vfy_lat_nx = vfy_lat;
    bit_cnt_nx = bit_cnt;
    wbl_nx     = wbl;
    shreg_nx   = shreg;
    head_nx    = ccff_head;
    clk_en_nx  = 1'b0;
    error_nx   = error;
    err_cnt_nx = err_cnt;

    // Readback compare: tail carries the bit shifted CHAIN_LEN shifts ago.
    if (state == S_VERIFY && ccff_clk_en && (ccff_tail != ccff_head)) begin
      error_nx   = 1'b1;
      err_cnt_nx = sat_inc(err_cnt);
    end

    if (abort) begin
      state_nx = S_IDLE;
      wbl_nx   = '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_nx   = S_LOAD;
            vfy_lat_nx = verify;
            bit_cnt_nx = '0;
            wbl_nx     = '0;
            error_nx   = 1'b0;
            err_cnt_nx = '0;
          end
        end
        S_LOAD, S_VERIFY: begin
          if (pass_end) begin
            state_nx = (state == S_LOAD && vfy_lat) ? S_VERIFY : S_DONE;
          end
          bit_cnt_nx = cnt_base;
          if (take) begin
            head_nx    = cfg_data[WORD_W-1];
            shreg_nx   = cfg_data << 1;
            wbl_nx     = word_bits(LEN_C - cnt_base) - 1'b1;
            bit_cnt_nx = cnt_base + 1'b1;
            clk_en_nx  = 1'b1;
          end else if (wbl != '0) begin
            head_nx    = shreg[WORD_W-1];
            shreg_nx   = shreg << 1;
            wbl_nx     = wbl - 1'b1;
            bit_cnt_nx = bit_cnt + 1'b1;
            clk_en_nx  = 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end

    // Ready in the cycle that shifts a word's last bit, so words stream with
    // no bubble; also across the load/verify boundary.
    ready_nx = ((state_nx == S_LOAD) || (state_nx == S_VERIFY)) &&
               (wbl_nx == '0) &&
               ((bit_cnt_nx != LEN_C) || (state_nx == S_LOAD && vfy_lat_nx));
    busy_nx  = (state_nx == S_LOAD) || (state_nx == S_VERIFY);
    done_nx  = (state_nx == S_DONE);
  end

  // State register.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) state <= S_IDLE;
    else           state <= state_nx;
  end

  // Control counters and registered outputs.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      vfy_lat     <= 1'b0;
      bit_cnt     <= '0;
      wbl         <= '0;
      ccff_head   <= 1'b0;
      ccff_clk_en <= 1'b0;
      cfg_ready   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      vfy_lat     <= vfy_lat_nx;
      bit_cnt     <= bit_cnt_nx;
      wbl         <= wbl_nx;
      ccff_head   <= head_nx;
      ccff_clk_en <= clk_en_nx;
      cfg_ready   <= ready_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      error       <= error_nx;
      err_cnt     <= err_cnt_nx;
    end
  end

  // Word shift register; pure data, qualified by wbl so it needs no reset.
  always_ff @(posedge prog_clk) begin
    shreg <= shreg_nx;
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a chain model on ccff_head/ccff_tail, a scoreboard
// of expected serial bits fed by the host driver, and a monitor that pops
// and compares on every ccff_clk_en pulse. A second small instance covers
// the partial final word and counter saturation.
module tb_ccff_loader;
  localparam int LEN  = 160;
  localparam int W    = 8;
  localparam int EW   = 8;
  localparam int LEN2 = 12;
  localparam int EW2  = 2;

  logic prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  logic          pReset_n = 1'b0;
  logic          start = 1'b0, verify = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [W-1:0]  cfg_data = '0;
  logic          cfg_ready, ccff_head, ccff_clk_en, ccff_tail, busy, done, error;
  logic [EW-1:0] err_cnt;

  logic          start2 = 1'b0, verify2 = 1'b0, abort2 = 1'b0, cfg_valid2 = 1'b0;
  logic [W-1:0]  cfg_data2 = '0;
  logic          ready2, head2, clk_en2, tail2, busy2, done2, error2;
  logic [EW2-1:0] err_cnt2;

  ccff_loader #(.CHAIN_LEN(LEN), .WORD_W(W), .ERRCNT_W(EW)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .verify(verify),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_clk_en(ccff_clk_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .error(error), .err_cnt(err_cnt)
  );

  ccff_loader #(.CHAIN_LEN(LEN2), .WORD_W(W), .ERRCNT_W(EW2)) dut12 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start2), .verify(verify2),
    .abort(abort2), .cfg_data(cfg_data2), .cfg_valid(cfg_valid2), .cfg_ready(ready2),
    .ccff_head(head2), .ccff_clk_en(clk_en2), .ccff_tail(tail2),
    .busy(busy2), .done(done2), .error(error2), .err_cnt(err_cnt2)
  );

  // Chain models: plain shift registers clocked by the enable.
  logic [LEN-1:0]  chain_q  = '0;
  logic [LEN2-1:0] chain2_q = '0;
  int   shift_cnt = 0;
  logic clr_cnt   = 1'b0;
  int   inv_idx   = -1;     // shift number at which the tail reads inverted
  logic inv2_all  = 1'b0;
  int   cyc = 0;

  assign ccff_tail = chain_q[LEN-1] ^ (shift_cnt == inv_idx);
  assign tail2     = chain2_q[LEN2-1] ^ inv2_all;

  always @(posedge prog_clk) begin
    cyc <= cyc + 1;
    if (clr_cnt) shift_cnt <= 0;
    else if (ccff_clk_en) shift_cnt <= shift_cnt + 1;
    if (ccff_clk_en) chain_q <= {chain_q[LEN-2:0], ccff_head};
    if (clk_en2) chain2_q <= {chain2_q[LEN2-2:0], head2};
  end

  int   n_tests = 0, n_fail = 0;
  int   start_cyc = 0;
  logic exp_q[$];
  logic exp2_q[$];
  logic pass_q[$];
  logic [W-1:0] wq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc - start_cyc);
    end
  endtask

  // Monitor: pops the expected bit on every shift pulse of either instance.
  task automatic monitor();
    forever begin
      @(negedge prog_clk);
      if (pReset_n && ccff_clk_en) begin
        if (exp_q.size() == 0) check("extra_shift", 32'(ccff_clk_en), 32'd0);
        else check("head_bit", 32'(ccff_head), 32'(exp_q.pop_front()));
      end
      if (pReset_n && clk_en2) begin
        if (exp2_q.size() == 0) check("extra_shift12", 32'(clk_en2), 32'd0);
        else check("head_bit12", 32'(head2), 32'(exp2_q.pop_front()));
      end
    end
  endtask

  task automatic do_start(input logic v);
    start = 1'b1; verify = v; clr_cnt = 1'b1; start_cyc = cyc;
    @(negedge prog_clk);
    start = 1'b0; verify = 1'b0; clr_cnt = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ready_after_start", 32'(cfg_ready), 32'd1);
  endtask

  task automatic wait_ready();
    int g = 0;
    while (!cfg_ready && g < 2000) begin @(negedge prog_clk); g++; end
    if (g >= 2000) check("ready_wait", 32'(cfg_ready), 32'd1);
  endtask

  // Presents one word (expected bits queued now), returns the cycle after accept.
  task automatic present(input logic [W-1:0] w, input int nb);
    cfg_data = w; cfg_valid = 1'b1;
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(w[W-1-b]);
      pass_q.push_back(w[W-1-b]);
    end
    wait_ready();
    @(negedge prog_clk);
    cfg_valid = 1'b0;
  endtask

  task automatic send_pass(input logic [W-1:0] words[$], input int stall_at,
                           input int stall_len, input int poke_at);
    int rem = LEN;
    int nb;
    pass_q.delete();
    for (int i = 0; i < words.size(); i++) begin
      nb  = (rem < W) ? rem : W;
      rem = rem - nb;
      if (i == poke_at) begin start = 1'b1; verify = 1'b1; end
      if (i == stall_at && stall_len > 0) begin
        cfg_valid = 1'b0;
        wait_ready();
        for (int k = 0; k < stall_len; k++) begin
          @(negedge prog_clk);
          check("stall_no_shift", 32'(ccff_clk_en), 32'd0);
        end
      end
      present(words[i], nb);
      start = 1'b0; verify = 1'b0;
    end
  endtask

  task automatic wait_done(input int lat);
    int g = 0;
    while (!done && g < 3000) begin @(negedge prog_clk); g++; end
    check("done_latency", 32'(cyc - start_cyc), 32'(lat));
  endtask

  task automatic check_result(input int shifts, input int errs);
    logic [LEN-1:0] e;
    e = '0;
    for (int k = 0; k < LEN; k++) e[LEN-1-k] = pass_q[k];
    check("shift_pulses", 32'(shift_cnt), 32'(shifts));
    check("err_cnt", 32'(err_cnt), 32'(errs));
    check("error_flag", 32'(error), 32'(errs != 0));
    check("busy_in_done", 32'(busy), 32'd0);
    n_tests++;
    if (chain_q !== e) begin
      n_fail++;
      $display("FAIL chain_contents: actual=%h required=%h", chain_q, e);
    end
  endtask

  task automatic present2(input logic [W-1:0] w, input int nb);
    int g = 0;
    cfg_data2 = w; cfg_valid2 = 1'b1;
    for (int b = 0; b < nb; b++) exp2_q.push_back(w[W-1-b]);
    while (!ready2 && g < 200) begin @(negedge prog_clk); g++; end
    if (g >= 200) check("ready_wait12", 32'(ready2), 32'd1);
    @(negedge prog_clk);
    cfg_valid2 = 1'b0;
  endtask

  task automatic run12(input logic v);
    int g = 0;
    start2 = 1'b1; verify2 = v; start_cyc = cyc;
    @(negedge prog_clk);
    start2 = 1'b0; verify2 = 1'b0;
    for (int p = 0; p < (v ? 2 : 1); p++) begin
      present2(8'hA5, 8);
      present2(8'h3C, 4);
    end
    while (!done2 && g < 50) begin
      check("ready12_after_last", 32'(ready2), 32'd0);
      @(negedge prog_clk); g++;
    end
    check("done12", 32'(done2), 32'd1);
    check("chain12", 32'(chain2_q), 32'hA53);
    check("bits12_consumed", 32'(exp2_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_at, s_len;
    logic v;
    fork monitor(); join_none

    // Reset state.
    repeat (3) @(negedge prog_clk);
    check("reset_outputs", 32'({cfg_ready, ccff_head, ccff_clk_en, busy, done, error, err_cnt}), 32'd0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    for (int i = 0; i < LEN / W; i++) wq.push_back(W'(i));

    // Basic load; a start pulse mid-load must be ignored.
    do_start(1'b0);
    send_pass(wq, -1, 0, 10);
    wait_done(LEN + 2);
    check_result(LEN, 0);

    // Backpressure: 5 idle cycles between words 3 and 4.
    do_start(1'b0);
    send_pass(wq, 4, 5, -1);
    wait_done(LEN + 2 + 5);
    check_result(LEN, 0);

    // Load plus verify, clean readback.
    do_start(1'b1);
    send_pass(wq, -1, 0, -1);
    send_pass(wq, -1, 0, -1);
    wait_done(2 * LEN + 2);
    check_result(2 * LEN, 0);

    // Load plus verify with one corrupted chain bit.
    inv_idx = LEN + 77;
    do_start(1'b1);
    send_pass(wq, -1, 0, -1);
    send_pass(wq, -1, 0, -1);
    wait_done(2 * LEN + 2);
    check_result(2 * LEN, 1);
    inv_idx = -1;

    // Abort after 37 shifts, then a fresh load counts from zero.
    do_start(1'b0);
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(8'($urandom));
    send_pass(wq, -1, 0, -1);
    while (cyc - start_cyc < 38) @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_ready", 32'(cfg_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_clk_en", 32'(ccff_clk_en), 32'd0);
    check("abort_shifts", 32'(shift_cnt), 32'd37);
    check("abort_leftover_bits", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    wq.delete();
    for (int i = 0; i < LEN / W; i++) wq.push_back(8'($urandom));
    do_start(1'b0);
    send_pass(wq, -1, 0, -1);
    wait_done(LEN + 2);
    check_result(LEN, 0);

    // Asynchronous reset in the middle of a verify pass.
    do_start(1'b1);
    send_pass(wq, -1, 0, -1);
    wq = wq[0:2];
    send_pass(wq, -1, 0, -1);
    @(negedge prog_clk);
    #2 pReset_n = 1'b0;
    #1 check("async_reset_outputs",
             32'({cfg_ready, ccff_head, ccff_clk_en, busy, done, error, err_cnt}), 32'd0);
    exp_q.delete();
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    check("idle_after_reset", 32'({busy, cfg_ready}), 32'd0);

    // Randomized words, stalls, verify and corruption.
    for (int r = 0; r < 4; r++) begin
      v = r[0];
      wq.delete();
      for (int i = 0; i < LEN / W; i++) wq.push_back(8'($urandom));
      s_at  = $urandom_range(1, LEN / W - 1);
      s_len = $urandom_range(1, 6);
      inv_idx = (v && r > 1) ? LEN + $urandom_range(0, LEN - 1) : -1;
      do_start(v);
      send_pass(wq, s_at, s_len, -1);
      if (v) send_pass(wq, -1, 0, -1);
      wait_done(LEN + 2 + s_len + (v ? LEN : 0));
      check_result(v ? 2 * LEN : LEN, (inv_idx >= 0) ? 1 : 0);
      inv_idx = -1;
    end

    // Short chain: partial final word, then saturating mismatch count.
    run12(1'b0);
    check("err12_clean", 32'({error2, err_cnt2}), 32'd0);
    inv2_all = 1'b1;
    run12(1'b1);
    check("err12_saturated", 32'(err_cnt2), 32'd3);
    check("error12_flag", 32'(error2), 32'd1);
    inv2_all = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
